// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word fall-through output.
// Registered status flags (wr_request, rd_request, reserve) are derived from
// the next-state occupancy, so they are valid in the cycle after each edge.
// Optional sticky error outputs are enabled by defining SYNC_FIFO_ERR_EN.
module sync_fifo #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16,
    parameter int RESERVE    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  wr_request,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_request,
    output logic                  reserve,
    output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                  overflow_err,
    output logic                  underflow_err
`endif
);

    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam int RESV_INT = DEPTH - RESERVE;

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   RESV_LEVEL = RESV_INT[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [ADDR_WIDTH:0]   next_count;

    // Decide which operations are accepted this cycle and the resulting occupancy
    always_comb begin
        rd_accept  = 1'b0;
        wr_accept  = 1'b0;
        next_count = count;
        rd_accept  = rd_en && (count != '0);
        wr_accept  = wr_en && ((count != FULL_COUNT) || rd_accept);
        if (wr_accept && !rd_accept) begin
            next_count = count + CNT_ONE;
        end else if (rd_accept && !wr_accept) begin
            next_count = count - CNT_ONE;
        end
    end

    // Storage array is deliberately left out of reset; only pointers clear
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and status flags registered from the next occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wr_request <= 1'b1;
            rd_request <= 1'b0;
            reserve    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count      <= next_count;
            wr_request <= (next_count != FULL_COUNT);
            rd_request <= (next_count != '0);
            reserve    <= (next_count >= RESV_LEVEL);
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    // Sticky error flags; a read paired with a write on an empty FIFO is not an underflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_en && !wr_accept) begin
                overflow_err <= 1'b1;
            end
            if (rd_en && !wr_en && (count == '0)) begin
                underflow_err <= 1'b1;
            end
        end
    end
`endif

    assign data_out = mem[rd_ptr];

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo at
// ADDR_WIDTH=3, DATA_WIDTH=16, RESERVE=2 (default build, no error ports).
module tb_sync_fifo;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [15:0] data_in;
    logic        wr_request;
    logic        rd_en;
    logic [15:0] data_out;
    logic        rd_request;
    logic        reserve;
    logic [3:0]  count;

    int compare_count;
    int mismatch_count;

    sync_fifo #(
        .ADDR_WIDTH (3),
        .DATA_WIDTH (16),
        .RESERVE    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .wr_request (wr_request),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .rd_request (rd_request),
        .reserve    (reserve),
        .count      (count)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and log any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then settle 1 ns after it
    task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] data);
        wr_en   = wr;
        rd_en   = rd;
        data_in = data;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 16'h0000;
    endtask

    // Directed sequence covering reset, fill, drain, concurrent ops, streaming and mid-op reset
    initial begin
        compare_count  = 0;
        mismatch_count = 0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 16'h0000;
        reset   = 1'b1;

        #1;
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_wr_request", 32'(wr_request), 32'd1);
        checkOutput("reset_rd_request", 32'(rd_request), 32'd0);
        checkOutput("reset_reserve", 32'(reserve), 32'd0);

        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Fill 1..8
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(i));
            checkOutput($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
            checkOutput($sformatf("fill_reserve_%0d", i), 32'(reserve), (i >= 6) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fill_wr_request_%0d", i), 32'(wr_request), (i < 8) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fill_rd_request_%0d", i), 32'(rd_request), 32'd1);
            checkOutput($sformatf("fill_head_%0d", i), 32'(data_out), 32'd1);
        end

        // Ninth write is dropped
        applyStimulus(1'b1, 1'b0, 16'h0099);
        checkOutput("overfill_count", 32'(count), 32'd8);
        checkOutput("overfill_wr_request", 32'(wr_request), 32'd0);
        checkOutput("overfill_head", 32'(data_out), 32'd1);

        // Drain 1..8
        for (int i = 1; i <= 8; i++) begin
            checkOutput($sformatf("drain_data_%0d", i), 32'(data_out), 32'(i));
            applyStimulus(1'b0, 1'b1, 16'h0000);
            checkOutput($sformatf("drain_count_%0d", i), 32'(count), 32'(8 - i));
            checkOutput($sformatf("drain_reserve_%0d", i), 32'(reserve), ((8 - i) >= 6) ? 32'd1 : 32'd0);
            checkOutput($sformatf("drain_rd_request_%0d", i), 32'(rd_request), (i < 8) ? 32'd1 : 32'd0);
            checkOutput($sformatf("drain_wr_request_%0d", i), 32'(wr_request), 32'd1);
        end

        // Read on empty is ignored
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("empty_read_count", 32'(count), 32'd0);
        checkOutput("empty_read_rd_request", 32'(rd_request), 32'd0);

        // Refill, then concurrent write/read while full
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(i));
        end
        checkOutput("refill_count", 32'(count), 32'd8);
        applyStimulus(1'b1, 1'b1, 16'h00AA);
        checkOutput("full_rw_count", 32'(count), 32'd8);
        checkOutput("full_rw_head", 32'(data_out), 32'd2);
        checkOutput("full_rw_wr_request", 32'(wr_request), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            checkOutput($sformatf("full_rw_drain_%0d", i), 32'(data_out), (i < 8) ? 32'(i + 1) : 32'h00AA);
            applyStimulus(1'b0, 1'b1, 16'h0000);
        end
        checkOutput("full_rw_end_count", 32'(count), 32'd0);

        // Concurrent write/read while empty: only the write is taken
        applyStimulus(1'b1, 1'b1, 16'h1234);
        checkOutput("empty_rw_count", 32'(count), 32'd1);
        checkOutput("empty_rw_data", 32'(data_out), 32'h1234);
        checkOutput("empty_rw_rd_request", 32'(rd_request), 32'd1);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("empty_rw_pop_count", 32'(count), 32'd0);

        // Streaming for 40 cycles; pointers wrap five times
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                checkOutput($sformatf("stream_pre_%0d", k), 32'(data_out), 32'(16'h0100 + 16'(k - 1)));
            end
            applyStimulus(1'b1, 1'b1, 16'h0100 + 16'(k));
            checkOutput($sformatf("stream_count_%0d", k), 32'(count), 32'd1);
            checkOutput($sformatf("stream_data_%0d", k), 32'(data_out), 32'(16'h0100 + 16'(k)));
        end
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkOutput("stream_end_count", 32'(count), 32'd0);

        // Reset asserted between edges with five words stored
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(16'h0200 + 16'(i)));
        end
        checkOutput("midreset_pre_count", 32'(count), 32'd5);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_count", 32'(count), 32'd0);
        checkOutput("midreset_rd_request", 32'(rd_request), 32'd0);
        checkOutput("midreset_wr_request", 32'(wr_request), 32'd1);
        checkOutput("midreset_reserve", 32'(reserve), 32'd0);
        #1;
        reset = 1'b0;
        @(negedge clk);

        // First write after reset is accepted at the next edge
        wr_en   = 1'b1;
        data_in = 16'h0055;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        checkOutput("post_reset_count", 32'(count), 32'd1);
        checkOutput("post_reset_data", 32'(data_out), 32'h0055);
        checkOutput("post_reset_rd_request", 32'(rd_request), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and reset.
REQ-002 Parameter ADDR_WIDTH, 3, log2 of storage depth; DEPTH = 2**ADDR_WIDTH; legal range 1..10.
REQ-003 Parameter DATA_WIDTH, 16, word width in bits.
REQ-004 Parameter RESERVE, 2, free-slot threshold for the reserve flag; legal range 1..DEPTH-1.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-high clear.
REQ-007 wr_en  input  1  write enable.
REQ-008 data_in  input  DATA_WIDTH  word to be written.
REQ-009 wr_request  output  1  high = not full (write will be accepted).
REQ-010 rd_en  input  1  read enable (pop).
REQ-011 data_out  output  DATA_WIDTH  head word, first-word fall-through.
REQ-012 rd_request  output  1  high = not empty (data_out valid).
REQ-013 reserve  output  1  high when free slots <= RESERVE.
REQ-014 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-015 The block SHALL accept a read when rd_en=1 and count>0; otherwise rd_en SHALL be ignored.
REQ-016 The block SHALL accept a write when wr_en=1 and either count<DEPTH or a read is accepted in the same cycle.
REQ-017 When full, a simultaneous write and read SHALL both be accepted and count SHALL stay DEPTH.
REQ-018 When empty, a simultaneous write and read SHALL accept only the write; there is no bypass, and count SHALL become 1.
REQ-019 count SHALL change by +1 (write only), -1 (read only) or 0 (both or neither) at each rising edge.
REQ-020 Read and write pointers SHALL be ADDR_WIDTH bits wide and wrap from DEPTH-1 to 0.
REQ-021 wr_request, rd_request and reserve SHALL be registered, derived from the next-state count, and valid in the cycle after the causing edge.
REQ-022 data_out SHALL present mem[rd_ptr] combinationally; a word written at edge N SHALL be visible on data_out and flagged by rd_request after edge N (latency 1 cycle); data_out is don't-care while rd_request=0.
REQ-023 reserve SHALL be high when count >= DEPTH-RESERVE, and low otherwise.
REQ-024 Words SHALL be delivered in write order, with no loss or duplication.

Reset
REQ-025 While reset=1 the block SHALL hold: pointers=0, count=0, wr_request=1, rd_request=0, reserve=0, and error flags (if present)=0.
REQ-026 Assertion of reset mid-operation SHALL discard all contents immediately, independent of clk; the storage array SHALL NOT be reset.
REQ-027 The first write SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-028 Macro SYNC_FIFO_ERR_EN: when defined, the block SHALL add two outputs, overflow_err (1, sticky, set by wr_en=1 on a rejected write) and underflow_err (1, sticky, set by rd_en=1 when empty), cleared only by reset.
REQ-029 When SYNC_FIFO_ERR_EN is undefined, those ports SHALL be absent and rejected operations SHALL be dropped silently, with identical data-path behaviour.

Verification (ADDR_WIDTH=3, DATA_WIDTH=16, RESERVE=2)
REQ-030 Fill: write 1..8 with no reads -> reserve rises after the 6th write, wr_request=0 after the 8th, count=8; a 9th write with wr_en=1 is dropped.
REQ-031 Drain: from full, read 8 -> data_out 1..8 in order, rd_request=0 after the 8th, count=0, reserve falls after count reaches 5.
REQ-032 Full concurrent: at count=8, wr_en=rd_en=1 with data_in=0x00AA for 1 cycle -> count stays 8, head advances, 0x00AA is delivered 8th.
REQ-033 Empty concurrent: at count=0, wr_en=rd_en=1 with data_in=0x1234 -> count=1, data_out=0x1234 on the next cycle, no underflow.
REQ-034 Wrap/stream: continuous wr_en=rd_en=1 for 40 cycles with incrementing data -> output sequence equals input, pointers wrap 5 times, count stays <= 1.
REQ-035 Reset mid-op: at count=5, pulse reset between clock edges -> count=0, rd_request=0 immediately; with SYNC_FIFO_ERR_EN, a prior overflow_err=1 clears.
